// File: rtl/hamming_encode.sv
// Bit-serial extended-Hamming (32,26) SECDED encoder: walks codeword positions
// 1..31 one per clock, then inserts the five Hamming bits and overall parity.
module hamming_encode (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [25:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] code_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  pos_q, pos_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  syn_q, syn_d;
  logic        par_q, par_d;
  logic [25:0] data_q, data_d;
  logic [31:0] work_q, work_d;
  logic [31:0] code_q, code_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Positions 1,2,4,8,16 hold check bits; position 0 never reaches this test.
  function automatic logic is_pow2(input logic [4:0] p);
    return ((p & (p - 5'd1)) == 5'd0);
  endfunction

  function automatic logic xor_reduce5(input logic [4:0] v);
    return ^v;
  endfunction

  // Next-state logic: accept, scan one position per clock, insert parity.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    idx_d   = idx_q;
    syn_d   = syn_q;
    par_d   = par_q;
    data_d  = data_q;
    work_d  = work_q;
    code_d  = code_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = data_in;
          syn_d   = 5'd0;
          par_d   = 1'b0;
          pos_d   = 5'd1;
          idx_d   = 5'd0;
          work_d  = 32'h0000_0000;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (!is_pow2(pos_q)) begin
          work_d[pos_q] = data_q[idx_q];
          idx_d         = idx_q + 5'd1;
          if (data_q[idx_q]) begin
            syn_d = syn_q ^ pos_q;
            par_d = ~par_q;
          end else begin
            syn_d = syn_q;
          end
        end else begin
          idx_d = idx_q;
        end
        pos_d = pos_q + 5'd1;
        if (pos_q == 5'd31) begin
          state_d = S_PARITY;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_PARITY: begin
        work_d[1]  = syn_q[0];
        work_d[2]  = syn_q[1];
        work_d[4]  = syn_q[2];
        work_d[8]  = syn_q[3];
        work_d[16] = syn_q[4];
        // Data parity plus check-bit parity gives even weight over all 32 bits.
        work_d[0]  = par_q ^ xor_reduce5(syn_q);
        code_d     = work_d;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pos_q   <= 5'd0;
      idx_q   <= 5'd0;
      syn_q   <= 5'd0;
      par_q   <= 1'b0;
      data_q  <= 26'h000_0000;
      work_q  <= 32'h0000_0000;
      code_q  <= 32'h0000_0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      syn_q   <= syn_d;
      par_q   <= par_d;
      data_q  <= data_d;
      work_q  <= work_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign code_out = code_q;

endmodule

// File: tb/tb_hamming_encode.sv
// Directed and loopback bench for hamming_encode; the loopback side decodes
// codewords with an independent SECDED syndrome checker.
module tb_hamming_encode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [25:0] data_in = 26'h0;
  logic        busy;
  logic        done;
  logic [31:0] code_out;

  int n_cmp = 0;
  int n_bad = 0;

  hamming_encode dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .code_out (code_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {err_2bit, syndrome} as the receive-side checker would.
  function automatic logic [5:0] check_word(input logic [31:0] c);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 1; i < 32; i++)
      if (c[i]) s = s ^ i[4:0];
    return {((s != 5'd0) && !(^c)), s};
  endfunction

  function automatic logic [25:0] extract_data(input logic [31:0] c);
    logic [25:0] d;
    int k;
    d = 26'h0;
    k = 0;
    for (int i = 1; i < 32; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = c[i];
        k++;
      end
    end
    return d;
  endfunction

  task automatic encode_word(input logic [25:0] d, output logic [31:0] code,
                             output int lat, output bit ok);
    start = 1'b1;
    data_in = d;
    tick();
    start = 1'b0;
    data_in = ~d;
    lat = 0;
    ok = 1'b0;
    while (!ok && lat < 40) begin
      tick();
      lat++;
      if (done) ok = 1'b1;
    end
    code = code_out;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || code_out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b code=%h, required 0 0 00000000", busy, done, code_out);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    logic [25:0] dv [5];
    logic [31:0] ev [5];
    logic [31:0] c;
    int lat;
    bit ok;
    dv[0] = 26'h0000000; ev[0] = 32'h0000_0000;
    dv[1] = 26'h0000001; ev[1] = 32'h0000_000F;
    dv[2] = 26'h2000000; ev[2] = 32'h8001_0116;
    dv[3] = 26'h3FFFFFF; ev[3] = 32'hFFFF_FFFF;
    dv[4] = 26'h0000002; ev[4] = 32'h0000_0033;
    for (int i = 0; i < 5; i++) begin
      encode_word(dv[i], c, lat, ok);
      n_cmp++;
      if (!ok || lat != 32) begin
        n_bad++;
        $display("FAIL latency[%0d]: got %0d (done seen=%0b), required 32", i, lat, ok);
      end
      n_cmp++;
      if (c !== ev[i]) begin
        n_bad++;
        $display("FAIL vector[%0d]: code=%h, required %h", i, c, ev[i]);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0 || code_out !== ev[i]) begin
        n_bad++;
        $display("FAIL hold[%0d]: done=%b code=%h, required 0 %h", i, done, code_out, ev[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int extra;
    bit ok;
    start = 1'b1;
    data_in = 26'h0000001;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_start: busy=%b, required 1", busy);
    end
    lat = 0;
    ok = 1'b0;
    while (!ok && lat < 40) begin
      if (lat == 5 || lat == 20) begin
        start = 1'b1;
        data_in = 26'h3FFFFFF;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (done) ok = 1'b1;
    end
    start = 1'b0;
    n_cmp++;
    if (!ok || lat != 32 || code_out !== 32'h0000_000F) begin
      n_bad++;
      $display("FAIL busy_ignore: lat=%0d code=%h, required 32 0000000F", lat, code_out);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL busy_ignore_extra_done: %0d extra done pulses, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok;
    start = 1'b1;
    data_in = 26'h0000001;
    tick();
    data_in = 26'h2000000;
    lat = 0;
    ok = 1'b0;
    while (!ok && lat < 40) begin
      tick();
      lat++;
      if (done) ok = 1'b1;
    end
    n_cmp++;
    if (!ok || lat != 32 || code_out !== 32'h0000_000F) begin
      n_bad++;
      $display("FAIL b2b_first: lat=%0d code=%h, required 32 0000000F", lat, code_out);
    end
    tick();
    start = 1'b0;
    data_in = 26'h0;
    lat = 1;
    ok = 1'b0;
    while (!ok && lat < 40) begin
      tick();
      lat++;
      if (done) ok = 1'b1;
    end
    n_cmp++;
    if (!ok || lat != 33 || code_out !== 32'h8001_0116) begin
      n_bad++;
      $display("FAIL b2b_second: spacing=%0d code=%h, required 33 80010116", lat, code_out);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_scan();
    int extra;
    start = 1'b1;
    data_in = 26'h3FFFFFF;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || code_out !== 32'h0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_scan: busy=%b done=%b code=%h, required 0 0 00000000", busy, done, code_out);
    end
    rst = 1'b1;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || code_out !== 32'h0) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL reset_mid_scan_after: %0d cycles with done or code!=0, required 0", extra);
    end
  endtask

  task automatic test_loopback();
    logic [31:0] c, cf;
    logic [25:0] d;
    logic [5:0] r;
    int lat, f1, f2;
    bit ok;
    for (int n = 0; n < 1000; n++) begin
      d = 26'($urandom);
      encode_word(d, c, lat, ok);
      r = check_word(c);
      n_cmp++;
      if (!ok || lat != 32 || r !== 6'd0 || extract_data(c) !== d) begin
        n_bad++;
        $display("FAIL loopback[%0d]: data=%h code=%h lat=%0d err2/syn=%h data_back=%h, required lat 32 err2/syn 00 data %h",
                 n, d, c, lat, r, extract_data(c), d);
      end
      f1 = $urandom_range(31, 1);
      cf = c;
      cf[f1] = ~cf[f1];
      r = check_word(cf);
      n_cmp++;
      if (r !== {1'b0, 5'(f1)}) begin
        n_bad++;
        $display("FAIL flip1[%0d]: err2/syn=%h, required %h", n, r, {1'b0, 5'(f1)});
      end
      f2 = (f1 + $urandom_range(30, 1)) % 32;
      cf[f2] = ~cf[f2];
      r = check_word(cf);
      n_cmp++;
      if (r[5] !== 1'b1) begin
        n_bad++;
        $display("FAIL flip2[%0d]: err_2bit=%b, required 1", n, r[5]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_scan();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
